// File: rtl/multi_channel_interval_timer.sv
// Avalon-MM slave with NUM_CH independent down-counting interval timers.
// Each channel has its own period, prescaler, one-shot/continuous mode, snapshot and interrupt.
module multi_channel_interval_timer #(
   parameter int          NUM_CH         = 4,
   parameter int          DATA_WIDTH     = 32,
   parameter int          COUNTER_WIDTH  = 32,
   parameter int          PRESCALE_WIDTH = 16,
   parameter logic [31:0] RESET_PERIOD   = 32'h02FAF07F
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [$clog2(NUM_CH)+2:0]     address,
   input  logic                          chipselect,
   input  logic                          write_n,
   input  logic [DATA_WIDTH-1:0]         writedata,
   output logic [DATA_WIDTH-1:0]         readdata,
   output logic [NUM_CH-1:0]             irq,
   output logic                          irq_any
);

   localparam int CW = COUNTER_WIDTH;
   localparam int PW = PRESCALE_WIDTH;
   localparam logic [CW-1:0] PERIOD_RST = CW'(RESET_PERIOD);

   typedef enum logic [2:0] {
      REG_STATUS   = 3'd0,
      REG_CONTROL  = 3'd1,
      REG_PERIOD   = 3'd2,
      REG_SNAP     = 3'd3,
      REG_PRESCALE = 3'd4,
      REG_COUNT    = 3'd5
   } reg_e;

   logic [CW-1:0] period_q   [NUM_CH];
   logic [CW-1:0] period_d   [NUM_CH];
   logic [CW-1:0] counter_q  [NUM_CH];
   logic [CW-1:0] counter_d  [NUM_CH];
   logic [CW-1:0] snap_q     [NUM_CH];
   logic [CW-1:0] snap_d     [NUM_CH];
   logic [PW-1:0] prescale_q [NUM_CH];
   logic [PW-1:0] prescale_d [NUM_CH];
   logic [PW-1:0] pcnt_q     [NUM_CH];
   logic [PW-1:0] pcnt_d     [NUM_CH];

   logic [NUM_CH-1:0] to_q, to_d;
   logic [NUM_CH-1:0] run_q, run_d;
   logic [NUM_CH-1:0] ito_q, ito_d;
   logic [NUM_CH-1:0] cont_q, cont_d;
   logic [NUM_CH-1:0] force_reload_q, force_reload_d;

   logic [DATA_WIDTH-1:0] readdata_q, readdata_d;

   logic              wr_en;
   logic [31:0]       ch_sel;
   logic [2:0]        reg_idx;
   logic [NUM_CH-1:0] hit;
   logic [NUM_CH-1:0] tick;

   assign wr_en   = chipselect & ~write_n;
   assign ch_sel  = 32'(address >> 3);
   assign reg_idx = address[2:0];

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         hit[i]  = wr_en && (ch_sel == 32'(i));
         tick[i] = run_q[i] && (pcnt_q[i] == prescale_q[i]);
      end
   end

   // Later assignments override earlier ones: tick, then force_reload, then bus write.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         // NOTE: every output gets a default first so no path can infer a latch.
         period_d[i]       = period_q[i];
         counter_d[i]      = counter_q[i];
         snap_d[i]         = snap_q[i];
         prescale_d[i]     = prescale_q[i];
         to_d[i]           = to_q[i];
         run_d[i]          = run_q[i];
         ito_d[i]          = ito_q[i];
         cont_d[i]         = cont_q[i];
         force_reload_d[i] = 1'b0;

         if (!run_q[i] || tick[i]) pcnt_d[i] = '0;
         else                      pcnt_d[i] = pcnt_q[i] + 1'b1;

         if (tick[i]) begin
            if (counter_q[i] == '0) begin
               counter_d[i] = period_q[i];
               to_d[i]      = 1'b1;
               if (!cont_q[i]) run_d[i] = 1'b0;
            end else begin
               counter_d[i] = counter_q[i] - 1'b1;
            end
         end

         // Deferred reload picks up the period written on the previous edge.
         if (force_reload_q[i]) begin
            counter_d[i] = period_q[i];
            run_d[i]     = 1'b0;
         end

         if (hit[i]) begin
            case (reg_idx)
               REG_STATUS: to_d[i] = 1'b0;
               REG_CONTROL: begin
                  ito_d[i]  = writedata[0];
                  cont_d[i] = writedata[1];
                  if (writedata[2]) begin
                     run_d[i]  = 1'b1;
                     pcnt_d[i] = '0;
                  end else if (writedata[3]) begin
                     run_d[i] = 1'b0;
                  end
               end
               REG_PERIOD: begin
                  period_d[i]       = writedata[CW-1:0];
                  force_reload_d[i] = 1'b1;
                  pcnt_d[i]         = '0;
               end
               REG_SNAP: snap_d[i] = counter_q[i];
               REG_PRESCALE: begin
                  prescale_d[i] = writedata[PW-1:0];
                  pcnt_d[i]     = '0;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      readdata_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_sel == 32'(i)) begin
            case (reg_idx)
               REG_STATUS:   readdata_d = DATA_WIDTH'({run_q[i], to_q[i]});
               REG_CONTROL:  readdata_d = DATA_WIDTH'({cont_q[i], ito_q[i]});
               REG_PERIOD:   readdata_d = DATA_WIDTH'(period_q[i]);
               REG_SNAP:     readdata_d = DATA_WIDTH'(snap_q[i]);
               REG_PRESCALE: readdata_d = DATA_WIDTH'(prescale_q[i]);
               REG_COUNT:    readdata_d = DATA_WIDTH'(counter_q[i]);
               default:      readdata_d = '0;
            endcase
         end
      end
   end

   // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            period_q[i]   <= PERIOD_RST;
            counter_q[i]  <= PERIOD_RST;
            snap_q[i]     <= '0;
            prescale_q[i] <= '0;
            pcnt_q[i]     <= '0;
         end
         to_q           <= '0;
         run_q          <= '0;
         ito_q          <= '0;
         cont_q         <= '0;
         force_reload_q <= '0;
         readdata_q     <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            period_q[i]   <= period_d[i];
            counter_q[i]  <= counter_d[i];
            snap_q[i]     <= snap_d[i];
            prescale_q[i] <= prescale_d[i];
            pcnt_q[i]     <= pcnt_d[i];
         end
         to_q           <= to_d;
         run_q          <= run_d;
         ito_q          <= ito_d;
         cont_q         <= cont_d;
         force_reload_q <= force_reload_d;
         readdata_q     <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = to_q & ito_q;
   assign irq_any  = |irq;

endmodule

// File: tb/tb_multi_channel_interval_timer.sv
// Directed bench for multi_channel_interval_timer: hand-computed register and IRQ timing vectors.
module tb_multi_channel_interval_timer;

   localparam logic [31:0] RST_PERIOD = 32'h02FAF07F;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [3:0]  irq;
   logic        irq_any;

   int n_vec = 0;
   int n_err = 0;

   multi_channel_interval_timer dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq),
      .irq_any    (irq_any)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Each bus access occupies exactly one rising edge and returns 1 time unit after it.
   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
      @(negedge clk);
      address = a;
      @(posedge clk);
      #1;
      check(tag, readdata, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset values
      #12;
      check("rst_readdata", readdata, 32'h0);
      check("rst_irq", {27'h0, irq_any, irq}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      rd_check("rst_period0", 5'd2, RST_PERIOD);
      rd_check("rst_status0", 5'd0, 32'h0);
      rd_check("rst_count0", 5'd5, RST_PERIOD);
      rd_check("rst_prescale0", 5'd4, 32'h0);
      rd_check("reserved6", 5'd6, 32'h0);

      // ch1 continuous, period 9, no prescale: terminal every 10 clocks
      wr(5'd10, 32'd9);
      wr(5'd12, 32'd0);
      wr(5'd9, 32'h7);
      cycles(9);
      check("ch1_irq_before", 32'(irq[1]), 32'd0);
      cycles(1);
      check("ch1_irq_set", 32'(irq[1]), 32'd1);
      check("ch1_irq_any", 32'(irq_any), 32'd1);
      wr(5'd8, 32'h0);
      check("ch1_irq_clr", 32'(irq[1]), 32'd0);
      cycles(8);
      check("ch1_irq_before2", 32'(irq[1]), 32'd0);
      cycles(1);
      check("ch1_irq_set2", 32'(irq[1]), 32'd1);

      // ch2 one-shot, period 3, prescale 4: single terminal after 20 clocks
      wr(5'd18, 32'd3);
      wr(5'd20, 32'd4);
      wr(5'd17, 32'h5);
      cycles(19);
      check("ch2_irq_before", 32'(irq[2]), 32'd0);
      cycles(1);
      check("ch2_irq_set", 32'(irq[2]), 32'd1);
      rd_check("ch2_status", 5'd16, 32'h1);
      rd_check("ch2_count", 5'd21, 32'd3);
      wr(5'd16, 32'h0);
      cycles(200);
      check("ch2_no_rearm", 32'(irq[2]), 32'd0);
      rd_check("ch2_count_held", 5'd21, 32'd3);
      rd_check("ch2_status_idle", 5'd16, 32'h0);

      // ch0 period rewrite while running, then START+STOP together
      wr(5'd2, 32'd1000);
      wr(5'd1, 32'h6);
      repeat (499) @(posedge clk);
      rd_check("ch0_count_run", 5'd5, 32'd501);
      wr(5'd2, 32'd50);
      @(posedge clk);
      rd_check("ch0_count_reload", 5'd5, 32'd50);
      rd_check("ch0_status_stop", 5'd0, 32'h0);
      rd_check("ch0_period", 5'd2, 32'd50);
      wr(5'd1, 32'hC);
      rd_check("ch0_start_wins", 5'd0, 32'h2);
      rd_check("ch0_control", 5'd1, 32'h0);

      // ch3 snapshot and STATUS clear colliding with a terminal event
      wr(5'd26, 32'd100);
      wr(5'd25, 32'h6);
      repeat (23) @(posedge clk);
      wr(5'd27, 32'h0);
      rd_check("ch3_snap", 5'd27, 32'd77);
      rd_check("ch3_count_live", 5'd29, 32'd75);
      repeat (74) @(posedge clk);
      wr(5'd24, 32'h0);
      rd_check("ch3_clear_wins", 5'd24, 32'h2);
      rd_check("ch3_count_reload", 5'd29, 32'd99);

      // Asynchronous reset while ch1 is running with its irq raised
      check("ch1_irq_pre_reset", 32'(irq[1]), 32'd1);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("async_irq", {27'h0, irq_any, irq}, 32'h0);
      check("async_readdata", readdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      rd_check("ch1_count_rst", 5'd13, RST_PERIOD);
      rd_check("ch1_status_rst", 5'd8, 32'h0);
      cycles(5);
      rd_check("ch1_count_still", 5'd13, RST_PERIOD);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
